// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM state, last-grant owner,
// default access latency and access-counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_ACC = 2'd1,
        DBG_ACC  = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_DBG  = 1'b1
    } gnt_t;

    localparam int WAIT_CYCLES_DEFAULT = 2;
    // Wide enough for a load value of WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Access-latency down-counter: load at grant, decrement each access cycle,
// zero flag marks the last access cycle.
module mem_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (core, debug/DMA) arbiter onto one fixed-latency memory port.
// Debug port and round-robin exist only when MEM_ARB_DBG_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          CoreReq,
    input  logic          CoreWe,
    input  logic [AW-1:0] CoreAdr,
    input  logic [DW-1:0] CoreWD,
    output logic [DW-1:0] CoreRD,
    output logic          CoreStall,
    input  logic          DbgReq,
    input  logic          DbgWe,
    input  logic [AW-1:0] DbgAdr,
    input  logic [DW-1:0] DbgWD,
    output logic [DW-1:0] DbgRD,
    output logic          DbgAck,
    output logic          MemEn,
    output logic          MemWE,
    output logic [AW-1:0] MemAdr,
    output logic [DW-1:0] MemWD,
    input  logic [DW-1:0] MemRD
);

    state_t           state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt;
    logic             grant_core, access, last_step, done_core;
    logic [AW-1:0]    adr_q;
    logic [DW-1:0]    wd_q;
    logic             we_q;
    logic [DW-1:0]    core_rd_q;

`ifdef MEM_ARB_DBG_EN
    gnt_t          last_gnt_q;
    logic          grant_dbg, dbg_wins;
    logic [DW-1:0] dbg_rd_q;

    // On a tie the requester not served last wins.
    assign dbg_wins   = DbgReq && (!CoreReq || (last_gnt_q == GNT_CORE));
    assign grant_dbg  = (state_q == IDLE) && dbg_wins;
    assign grant_core = (state_q == IDLE) && CoreReq && !dbg_wins;
    assign access     = (state_q == CORE_ACC) || (state_q == DBG_ACC);
    assign done_core  = (state_q == DONE) && (last_gnt_q == GNT_CORE);
    assign DbgAck     = (state_q == DONE) && (last_gnt_q == GNT_DBG);
    assign DbgRD      = dbg_rd_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            last_gnt_q <= GNT_DBG;
            dbg_rd_q   <= '0;
        end else begin
            if (grant_core) begin
                last_gnt_q <= GNT_CORE;
            end else if (grant_dbg) begin
                last_gnt_q <= GNT_DBG;
            end
            if ((state_q == DBG_ACC) && cnt_zero && !we_q) begin
                dbg_rd_q <= MemRD;
            end
        end
    end
`else
    logic unused_dbg;

    assign unused_dbg = ^{DbgReq, DbgWe, DbgAdr, DbgWD};
    assign grant_core = (state_q == IDLE) && CoreReq;
    assign access     = (state_q == CORE_ACC);
    assign done_core  = (state_q == DONE);
    assign DbgAck     = 1'b0;
    assign DbgRD      = '0;
`endif

    assign last_step = access && cnt_zero;

    mem_wait_counter u_wait_counter (
        .clk      (clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES - 1)),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_core) begin
                    state_d  = CORE_ACC;
                    cnt_load = 1'b1;
`ifdef MEM_ARB_DBG_EN
                end else if (grant_dbg) begin
                    state_d  = DBG_ACC;
                    cnt_load = 1'b1;
`endif
                end
            end
`ifdef MEM_ARB_DBG_EN
            CORE_ACC, DBG_ACC: begin
`else
            CORE_ACC: begin
`endif
                if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requester inputs are only looked at on the grant edge.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            adr_q     <= '0;
            wd_q      <= '0;
            we_q      <= 1'b0;
            core_rd_q <= '0;
        end else begin
            if (grant_core) begin
                adr_q <= CoreAdr;
                wd_q  <= CoreWD;
                we_q  <= CoreWe;
`ifdef MEM_ARB_DBG_EN
            end else if (grant_dbg) begin
                adr_q <= DbgAdr;
                wd_q  <= DbgWD;
                we_q  <= DbgWe;
`endif
            end
            if ((state_q == CORE_ACC) && cnt_zero && !we_q) begin
                core_rd_q <= MemRD;
            end
        end
    end

    assign MemEn     = access;
    assign MemWE     = last_step && we_q;
    assign MemAdr    = adr_q;
    assign MemWD     = wd_q;
    assign CoreRD    = core_rd_q;
    assign CoreStall = CoreReq && !done_core;

endmodule
